// File: rtl/pipe_delay_line.sv
// pipe_delay_line: runtime-programmable register delay line with valid/ready
// handshake, global stall, synchronous flush and occupancy count.
// The active latency L is a registered, clamped copy of delay_sel that only
// reloads while the chain is empty and idle, so in-flight words always see
// a consistent latency.
// Optional feature: define PIPE_DELAY_STATS_EN to add the stall_cnt and
// xfer_cnt statistics outputs.
module pipe_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic [SEL_W-1:0] delay_sel,
  input  logic             flush,
`ifdef PIPE_DELAY_STATS_EN
  output logic [15:0]      stall_cnt,
  output logic [15:0]      xfer_cnt,
`endif
  output logic [SEL_W-1:0] occupancy
);

  // Clamp a requested latency into the legal range 1..DEPTH.
  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] sel);
    logic [SEL_W-1:0] r;
    if (sel == {SEL_W{1'b0}}) begin
      r = SEL_W'(1);
    end else if (sel > SEL_W'(DEPTH)) begin
      r = SEL_W'(DEPTH);
    end else begin
      r = sel;
    end
    return r;
  endfunction

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [SEL_W-1:0] l_q, l_d;
  logic [SEL_W-1:0] occ_q, occ_d;
  logic             tap_v_s;
  logic [WIDTH-1:0] tap_data_s;
  logic             advance_s;
  logic             load_l_s;

  // Select the tap stage S[L-1] that drives the output.
  always_comb begin
    tap_v_s    = 1'b0;
    tap_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (l_q == SEL_W'(i + 1)) begin
        tap_v_s    = v_q[i];
        tap_data_s = data_q[i];
      end else begin
        tap_v_s    = tap_v_s;
        tap_data_s = tap_data_s;
      end
    end
  end

  assign advance_s = ~tap_v_s | out_ready;
  assign in_ready  = advance_s;
  assign out_valid = tap_v_s;
  assign out_data  = tap_data_s;
  assign occupancy = occ_q;

  // Latency reload: only when the chain is empty and nothing is entering.
  always_comb begin
    load_l_s = (occ_q == {SEL_W{1'b0}}) && !(in_valid && advance_s);
    if (load_l_s) begin
      l_d = clamp_sel(delay_sel);
    end else begin
      l_d = l_q;
    end
  end

  // Stage next-state: shift on advance, zero inactive stages, flush clears valids.
  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    if (advance_s) begin
      v_d[0]    = in_valid;
      data_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (SEL_W'(i) < l_q) begin
          v_d[i]    = v_q[i-1];
          data_d[i] = data_q[i-1];
        end else begin
          v_d[i]    = 1'b0;
          data_d[i] = {WIDTH{1'b0}};
        end
      end
    end else begin
      v_d = v_q;
    end
    if (flush) begin
      v_d = {DEPTH{1'b0}};
    end else begin
      v_d = v_d;
    end
  end

  // Occupancy of the next state: count valid words in the active stages.
  always_comb begin
    occ_d = {SEL_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (SEL_W'(i) < l_q) begin
        occ_d = occ_d + {{(SEL_W-1){1'b0}}, v_d[i]};
      end else begin
        occ_d = occ_d;
      end
    end
  end

  // Stage, latency and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= {DEPTH{1'b0}};
      l_q   <= SEL_W'(1);
      occ_q <= {SEL_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      v_q   <= v_d;
      l_q   <= l_d;
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

`ifdef PIPE_DELAY_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Saturating statistics counters, cleared by flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (flush) begin
      stall_cnt_d = 16'h0000;
      xfer_cnt_d  = 16'h0000;
    end else begin
      if (tap_v_s && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'h0001;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (tap_v_s && out_ready && (xfer_cnt_q != 16'hFFFF)) begin
        xfer_cnt_d = xfer_cnt_q + 16'h0001;
      end else begin
        xfer_cnt_d = xfer_cnt_q;
      end
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
      xfer_cnt_q  <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign xfer_cnt  = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_delay_line.sv
// Self-checking bench for pipe_delay_line: a directed vector table, directed
// multi-cycle sequences, and a randomized run against a queue-based model in
// which each word carries its age in advance cycles and appears at the
// output once its age equals the active latency.
module tb_pipe_delay_line;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int SEL_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready, flush;
  logic [WIDTH-1:0] in_data, out_data;
  logic [SEL_W-1:0] delay_sel, occupancy;
`ifdef PIPE_DELAY_STATS_EN
  logic [15:0]      stall_cnt, xfer_cnt;
`endif

  always #5 clk = ~clk;

  pipe_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .delay_sel(delay_sel), .flush(flush),
`ifdef PIPE_DELAY_STATS_EN
    .stall_cnt(stall_cnt), .xfer_cnt(xfer_cnt),
`endif
    .occupancy(occupancy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  typedef struct { logic [7:0] d; int age; } word_t;
  word_t mq[$];
  int    mL = 1;

  // Observations and tracking.
  logic       obs_ov, obs_rdy;
  logic [7:0] obs_od;
  logic [3:0] obs_occ;
  int         cyc = 0;
  int         first_ov_cyc, last_ov_cyc, peak_occ;
  logic [7:0] rx[$];

  function automatic int clampf(input int s);
    if (s == 0) return 1;
    else if (s > DEPTH) return DEPTH;
    else return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clr_track();
    first_ov_cyc = -1;
    last_ov_cyc  = -1;
    peak_occ     = 0;
    rx.delete();
  endtask

  task automatic model_reset();
    mq.delete();
    mL = 1;
  endtask

  // One clock cycle: drive inputs, check outputs vs model mid-cycle, then
  // advance the model at the rising edge.
  task automatic cycle(input logic iv, input logic [7:0] dat, input logic ordy,
                       input logic [3:0] sel, input logic fl);
    logic       e_ov, e_rdy, adv, load;
    logic [7:0] e_od;
    int         e_occ;
    in_valid = iv; in_data = dat; out_ready = ordy; delay_sel = sel; flush = fl;
    @(negedge clk);
    e_ov  = (mq.size() > 0) && (mq[0].age == mL);
    e_od  = e_ov ? mq[0].d : 8'h00;
    e_occ = mq.size();
    e_rdy = !e_ov || ordy;
    obs_ov = out_valid; obs_od = out_data; obs_occ = occupancy; obs_rdy = in_ready;
    chk("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
    if (e_ov) chk("out_data", {24'b0, out_data}, {24'b0, e_od});
    chk("in_ready", {31'b0, in_ready}, {31'b0, e_rdy});
    chk("occupancy", {28'b0, occupancy}, e_occ);
    if (obs_ov) begin
      if (first_ov_cyc < 0) first_ov_cyc = cyc;
      last_ov_cyc = cyc;
      if (ordy) rx.push_back(obs_od);
    end
    if (int'(obs_occ) > peak_occ) peak_occ = int'(obs_occ);
    @(posedge clk);
    adv  = e_rdy;
    load = (mq.size() == 0) && !(iv && adv);
    if (fl) begin
      mq.delete();
    end else if (adv) begin
      for (int i = 0; i < mq.size(); i++) mq[i].age = mq[i].age + 1;
      if (mq.size() > 0 && mq[0].age > mL) void'(mq.pop_front());
      if (iv) mq.push_back('{d: dat, age: 1});
    end
    if (load) mL = clampf(int'(sel));
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] sel, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, ordy, sel, 1'b0);
  endtask

  typedef struct {
    logic iv; logic [7:0] d; logic ordy; logic fl;
    logic e_ov; logic [7:0] e_od; logic e_rdy; logic [3:0] e_occ;
  } vec_t;
  vec_t tbl[9];

  int start, nxt;
  logic [3:0] rsel;

  initial begin
    // Hand-computed vectors, L = 1 (delay_sel = 0).
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 4'd1};
    tbl[2] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0};
    tbl[3] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 4'd1};
    tbl[4] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 4'd1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 4'd1};
    tbl[6] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0};
    tbl[7] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 4'd1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    delay_sel = 4'd0; flush = 1'b0;
    model_reset();
    clr_track();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {24'b0, out_data}, 32'd0);
    chk("rst_occupancy", {28'b0, occupancy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].iv, tbl[i].d, tbl[i].ordy, 4'd0, tbl[i].fl);
      chk("tbl_out_valid", {31'b0, obs_ov}, {31'b0, tbl[i].e_ov});
      if (tbl[i].e_ov) chk("tbl_out_data", {24'b0, obs_od}, {24'b0, tbl[i].e_od});
      chk("tbl_in_ready", {31'b0, obs_rdy}, {31'b0, tbl[i].e_rdy});
      chk("tbl_occupancy", {28'b0, obs_occ}, {28'b0, tbl[i].e_occ});
    end

    // Programmed depth 5: ten back-to-back words.
    idle(1, 4'd5, 1'b1);
    clr_track();
    start = cyc;
    for (int k = 0; k < 10; k++) cycle(1'b1, 8'(k + 1), 1'b1, 4'd5, 1'b0);
    idle(8, 4'd5, 1'b1);
    chk("depth5_latency", first_ov_cyc - start, 32'd5);
    chk("depth5_contiguous", last_ov_cyc - first_ov_cyc, 32'd9);
    chk("depth5_peak_occ", peak_occ, 32'd5);
    chk("depth5_count", rx.size(), 32'd10);
    for (int k = 0; k < 10 && k < rx.size(); k++) chk("depth5_order", {24'b0, rx[k]}, k + 1);

    // Backpressure at latency 3.
    idle(2, 4'd3, 1'b1);
    clr_track();
    nxt = 0;
    for (int c = 0; c < 16; c++) begin
      cycle(nxt < 4, 8'h21 + 8'(nxt), !(c >= 3 && c < 7), 4'd3, 1'b0);
      if (c >= 3 && c < 7) begin
        chk("bp_in_ready_low", {31'b0, obs_rdy}, 32'd0);
        chk("bp_data_stable", {24'b0, obs_od}, 32'h21);
      end
      if (nxt < 4 && obs_rdy) nxt++;
    end
    chk("bp_count", rx.size(), 32'd4);
    for (int k = 0; k < 4 && k < rx.size(); k++) chk("bp_order", {24'b0, rx[k]}, 32'h21 + k);

    // Latency change gating: 2 -> 6 mid-stream.
    idle(2, 4'd2, 1'b1);
    clr_track();
    start = cyc;
    for (int k = 0; k < 6; k++) cycle(1'b1, 8'h40 + 8'(k), 1'b1, (k < 2) ? 4'd2 : 4'd6, 1'b0);
    idle(4, 4'd6, 1'b1);
    chk("gate_old_latency", first_ov_cyc - start, 32'd2);
    chk("gate_old_last", last_ov_cyc - start, 32'd7);
    chk("gate_count", rx.size(), 32'd6);
    clr_track();
    start = cyc;
    cycle(1'b1, 8'h55, 1'b1, 4'd6, 1'b0);
    idle(8, 4'd6, 1'b1);
    chk("gate_new_latency", first_ov_cyc - start, 32'd6);

    // Flush with three words in flight plus a new word.
    idle(1, 4'd4, 1'b1);
    clr_track();
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'h61 + 8'(k), 1'b1, 4'd4, 1'b0);
    cycle(1'b1, 8'hFF, 1'b1, 4'd4, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 4'd4, 1'b0);
    chk("flush_occ", {28'b0, obs_occ}, 32'd0);
    chk("flush_out_valid", {31'b0, obs_ov}, 32'd0);
    idle(8, 4'd4, 1'b1);
    chk("flush_no_output", rx.size(), 32'd0);

    // Clamp to DEPTH, then asynchronous reset with a word at the tap.
    idle(1, 4'd15, 1'b1);
    clr_track();
    start = cyc;
    cycle(1'b1, 8'hAB, 1'b0, 4'd15, 1'b0);
    idle(10, 4'd15, 1'b0);
    chk("clamp_latency", first_ov_cyc - start, 32'd8);
    chk("clamp_held", {31'b0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_out_data", {24'b0, out_data}, 32'd0);
    chk("async_occ", {28'b0, occupancy}, 32'd0);
    chk("async_in_ready", {31'b0, in_ready}, 32'd1);
    model_reset();
    #1 rst_n = 1'b1;
    cycle(1'b1, 8'h5A, 1'b1, 4'd15, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 4'd15, 1'b0);
    chk("post_rst_l1_valid", {31'b0, obs_ov}, 32'd1);
    chk("post_rst_l1_data", {24'b0, obs_od}, 32'h5A);

    // Randomized run against the model.
    rsel = 4'd3;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) rsel = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) < 7,
            rsel, $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
